// File: rtl/pointwise_mac_1x1.sv
// 1x1 pointwise convolution MAC: per-channel weight multiply, channel accumulate,
// bias add, floor rescale, saturation and optional ReLU, with frame tracking.
module pointwise_mac_1x1 #(
    parameter int DATA_WIDHT = 32,
    parameter int FRAC_BITS  = 16,
    parameter int CHANNELS   = 3,
    parameter int OUT_PIXELS = 22500,
    parameter int RELU_EN    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Cfg_We,
    input  logic [7:0]            Cfg_Addr,
    input  logic [DATA_WIDHT-1:0] Cfg_Data,
    input  logic [DATA_WIDHT-1:0] Data_In,
    input  logic                  Valid_In,
    output logic [DATA_WIDHT-1:0] Data_Out,
    output logic                  Valid_Out,
    output logic                  Frame_Done,
    output logic                  Cfg_Err
);

    localparam int PW    = 2 * DATA_WIDHT;
    localparam int AW    = PW + 8;
    localparam int SW    = AW + 1;
    localparam int PIX_W = (OUT_PIXELS > 1) ? $clog2(OUT_PIXELS) : 1;

    localparam logic [7:0]            LAST_CH  = 8'(CHANNELS - 1);
    localparam logic [PIX_W-1:0]      LAST_PIX = PIX_W'(OUT_PIXELS - 1);
    localparam logic signed [SW-1:0]  SAT_MAX  = {{(SW-DATA_WIDHT+1){1'b0}}, {(DATA_WIDHT-1){1'b1}}};
    localparam logic signed [SW-1:0]  SAT_MIN  = {{(SW-DATA_WIDHT+1){1'b1}}, {(DATA_WIDHT-1){1'b0}}};
    localparam logic [DATA_WIDHT-1:0] OUT_MAX  = {1'b0, {(DATA_WIDHT-1){1'b1}}};
    localparam logic [DATA_WIDHT-1:0] OUT_MIN  = {1'b1, {(DATA_WIDHT-1){1'b0}}};

    logic [DATA_WIDHT-1:0] w_q [CHANNELS];
    logic [DATA_WIDHT-1:0] bias_q;
    logic [7:0]            ch_q;
    logic                  cfg_err_q;

    logic                  p1_vld_q, p1_first_q, p1_last_q;
    logic signed [PW-1:0]  prod_q;
    logic signed [AW-1:0]  acc_q;
    logic                  acc_done_q;
    logic signed [SW-1:0]  sh_q;
    logic                  sh_vld_q;

    logic [DATA_WIDHT-1:0] dout_q;
    logic                  vout_q, frame_q;
    logic [PIX_W-1:0]      pix_q;

    logic [DATA_WIDHT-1:0] w_sel;
    logic signed [PW-1:0]  din_x, w_x, prod_d;
    logic signed [AW-1:0]  prod_x, acc_d;
    logic signed [SW-1:0]  bias_sh, sum_d, sh_d;
    logic [DATA_WIDHT-1:0] dout_d;
    logic                  cfg_busy;

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch_q == 8'(i)) w_sel = w_q[i];
        end
    end

    assign din_x   = {{DATA_WIDHT{Data_In[DATA_WIDHT-1]}}, Data_In};
    assign w_x     = {{DATA_WIDHT{w_sel[DATA_WIDHT-1]}}, w_sel};
    assign prod_d  = din_x * w_x;
    assign prod_x  = {{8{prod_q[PW-1]}}, prod_q};
    assign acc_d   = p1_first_q ? prod_x : acc_q + prod_x;
    assign bias_sh = {{(SW-DATA_WIDHT){bias_q[DATA_WIDHT-1]}}, bias_q} <<< FRAC_BITS;
    assign sum_d   = {acc_q[AW-1], acc_q} + bias_sh;
    assign sh_d    = sum_d >>> FRAC_BITS;

    always_comb begin
        if (sh_q > SAT_MAX)      dout_d = OUT_MAX;
        else if (sh_q < SAT_MIN) dout_d = OUT_MIN;
        else                     dout_d = sh_q[DATA_WIDHT-1:0];
        if (RELU_EN != 0 && sh_q[SW-1]) dout_d = '0;
    end

    // A sample arriving this cycle counts as in flight: a write now could split a pixel.
    assign cfg_busy = (ch_q != 8'd0) | Valid_In | p1_vld_q | acc_done_q | sh_vld_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < CHANNELS; i++) w_q[i] <= '0;
            bias_q     <= '0;
            ch_q       <= '0;
            cfg_err_q  <= 1'b0;
            p1_vld_q   <= 1'b0;
            p1_first_q <= 1'b0;
            p1_last_q  <= 1'b0;
            prod_q     <= '0;
            acc_q      <= '0;
            acc_done_q <= 1'b0;
            sh_q       <= '0;
            sh_vld_q   <= 1'b0;
            dout_q     <= '0;
            vout_q     <= 1'b0;
            frame_q    <= 1'b0;
            pix_q      <= '0;
        end else begin
            if (Cfg_We) begin
                if (cfg_busy) begin
                    cfg_err_q <= 1'b1;
                end else if (Cfg_Addr == 8'(CHANNELS)) begin
                    bias_q <= Cfg_Data;
                end else begin
                    for (int i = 0; i < CHANNELS; i++) begin
                        if (Cfg_Addr == 8'(i)) w_q[i] <= Cfg_Data;
                    end
                end
            end

            p1_vld_q <= Valid_In;
            if (Valid_In) begin
                ch_q       <= (ch_q == LAST_CH) ? 8'd0 : ch_q + 8'd1;
                prod_q     <= prod_d;
                p1_first_q <= (ch_q == 8'd0);
                p1_last_q  <= (ch_q == LAST_CH);
            end

            if (p1_vld_q) acc_q <= acc_d;
            acc_done_q <= p1_vld_q & p1_last_q;

            if (acc_done_q) sh_q <= sh_d;
            sh_vld_q <= acc_done_q;

            vout_q  <= sh_vld_q;
            frame_q <= sh_vld_q && (pix_q == LAST_PIX);
            if (sh_vld_q) begin
                dout_q <= dout_d;
                pix_q  <= (pix_q == LAST_PIX) ? '0 : pix_q + PIX_W'(1);
            end
        end
    end

    assign Data_Out   = dout_q;
    assign Valid_Out  = vout_q;
    assign Frame_Done = frame_q;
    assign Cfg_Err    = cfg_err_q;

endmodule

// File: tb/tb_pointwise_mac_1x1.sv
// Bench for pointwise_mac_1x1: ReLU and linear instances share stimulus and are
// compared against a wide-integer arithmetic reference model.
module tb_pointwise_mac_1x1;

    logic        clk = 1'b0;
    logic        rst;
    logic        Cfg_We;
    logic [7:0]  Cfg_Addr;
    logic [31:0] Cfg_Data, Data_In;
    logic        Valid_In;
    logic [31:0] dout_r, dout_n;
    logic        vo_r, vo_n, fd_r, fd_n, ce_r, ce_n;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    logic signed [31:0] m_w [3];
    logic signed [31:0] m_b;
    int                 m_pix;

    typedef struct {logic [31:0] r; logic [31:0] n; logic fd; int cyc;} exp_t;
    typedef struct {logic [31:0] r; logic [31:0] n; logic vr; logic vn; logic fr; logic fn; int cyc;} obs_t;
    exp_t exp_q[$];
    obs_t obs_q[$];

    pointwise_mac_1x1 #(.DATA_WIDHT(32), .FRAC_BITS(16), .CHANNELS(3), .OUT_PIXELS(4), .RELU_EN(1)) dut_relu (
        .clk(clk), .rst(rst), .Cfg_We(Cfg_We), .Cfg_Addr(Cfg_Addr), .Cfg_Data(Cfg_Data),
        .Data_In(Data_In), .Valid_In(Valid_In), .Data_Out(dout_r), .Valid_Out(vo_r),
        .Frame_Done(fd_r), .Cfg_Err(ce_r));

    pointwise_mac_1x1 #(.DATA_WIDHT(32), .FRAC_BITS(16), .CHANNELS(3), .OUT_PIXELS(4), .RELU_EN(0)) dut_lin (
        .clk(clk), .rst(rst), .Cfg_We(Cfg_We), .Cfg_Addr(Cfg_Addr), .Cfg_Data(Cfg_Data),
        .Data_In(Data_In), .Valid_In(Valid_In), .Data_Out(dout_n), .Valid_Out(vo_n),
        .Frame_Done(fd_n), .Cfg_Err(ce_n));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (vo_r || vo_n) obs_q.push_back('{dout_r, dout_n, vo_r, vo_n, fd_r, fd_n, cyc});
    end

    // Reference: exact sum of products, bias scaled into the product domain, floor rescale.
    function automatic logic [31:0] ref_out(input logic [31:0] d0, input logic [31:0] d1,
                                            input logic [31:0] d2, input bit relu);
        logic signed [127:0] acc, a, b, r;
        logic [31:0] d [3];
        d[0] = d0; d[1] = d1; d[2] = d2;
        acc = 0;
        for (int c = 0; c < 3; c++) begin
            a = $signed(d[c]);
            b = m_w[c];
            acc = acc + a * b;
        end
        b = m_b;
        acc = acc + b * 128'sd65536;
        r = acc >>> 16;
        if (r > 128'sd2147483647) r = 128'sd2147483647;
        else if (r < -128'sd2147483648) r = -128'sd2147483648;
        if (relu && r < 0) r = 0;
        return r[31:0];
    endfunction

    function automatic logic [31:0] rand_fix();
        logic signed [31:0] v;
        v = $urandom;
        return v >>> $urandom_range(8, 16);
    endfunction

    task automatic do_reset();
        Valid_In = 1'b0;
        Cfg_We   = 1'b0;
        rst      = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) m_w[c] = '0;
        m_b   = '0;
        m_pix = 0;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic cfg_write(input logic [7:0] addr, input logic [31:0] data, input bit ok);
        Cfg_Addr = addr;
        Cfg_Data = data;
        Cfg_We   = 1'b1;
        @(negedge clk);
        Cfg_We = 1'b0;
        if (ok) begin
            if (addr < 8'd3) m_w[addr] = data;
            else if (addr == 8'd3) m_b = data;
        end
    endtask

    task automatic drive_sample(input logic [31:0] d, output int cy);
        Data_In  = d;
        Valid_In = 1'b1;
        cy = cyc + 1;
        @(negedge clk);
        Valid_In = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] er, input logic [31:0] en, input int cy);
        exp_q.push_back('{er, en, (m_pix == 3), cy});
        m_pix = (m_pix + 1) % 4;
    endtask

    task automatic send_pixel(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                              input int max_gap, input bit use_model,
                              input logic [31:0] er_c, input logic [31:0] en_c);
        logic [31:0] d [3];
        int cy;
        d[0] = d0; d[1] = d1; d[2] = d2;
        cy = 0;
        for (int c = 0; c < 3; c++) begin
            repeat ($urandom_range(0, max_gap)) @(negedge clk);
            drive_sample(d[c], cy);
        end
        if (use_model) push_exp(ref_out(d0, d1, d2, 1'b1), ref_out(d0, d1, d2, 1'b0), cy);
        else           push_exp(er_c, en_c, cy);
    endtask

    task automatic load_random_cfg();
        for (int c = 0; c < 4; c++) cfg_write(8'(c), rand_fix(), 1'b1);
    endtask

    task automatic test_basic();
        for (int c = 0; c < 3; c++) cfg_write(8'(c), 32'h0001_0000, 1'b1);
        cfg_write(8'd3, 32'h0, 1'b1);
        send_pixel(32'h0002_0000, 32'h0002_0000, 32'h0002_0000, 0, 1'b0, 32'h0006_0000, 32'h0006_0000);
        for (int k = 0; k < 60 && obs_q.size() < exp_q.size(); k++) @(negedge clk);
        repeat (4) @(negedge clk);
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].r !== exp_q[i].r || obs_q[i].n !== exp_q[i].n || !obs_q[i].vr || !obs_q[i].vn) begin
                errors++; $display("FAIL basic_value[%0d] got=%h/%h exp=%h/%h", i, obs_q[i].r, obs_q[i].n, exp_q[i].r, exp_q[i].n); end
            checks++;
            if (obs_q[i].fr !== exp_q[i].fd || obs_q[i].fn !== exp_q[i].fd) begin
                errors++; $display("FAIL basic_frame[%0d] got=%b/%b exp=%b", i, obs_q[i].fr, obs_q[i].fn, exp_q[i].fd); end
            checks++;
            if (obs_q[i].cyc - exp_q[i].cyc != 3) begin
                errors++; $display("FAIL basic_latency[%0d] got=%0d exp=3", i, obs_q[i].cyc - exp_q[i].cyc); end
        end
        checks++;
        if (dout_r !== 32'h0006_0000 || vo_r !== 1'b0 || ce_r !== 1'b0) begin
            errors++; $display("FAIL basic_hold got=%h vo=%b err=%b exp=00060000 vo=0 err=0", dout_r, vo_r, ce_r); end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_bias_relu();
        cfg_write(8'd0, 32'hFFFF_0000, 1'b1);
        cfg_write(8'd3, 32'h0000_8000, 1'b1);
        send_pixel(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 0, 1'b0, 32'h0001_8000, 32'h0001_8000);
        for (int k = 0; k < 60 && obs_q.size() < exp_q.size(); k++) @(negedge clk);
        repeat (4) @(negedge clk);
        cfg_write(8'd3, 32'hFFFC_0000, 1'b1);
        send_pixel(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 0, 1'b0, 32'h0000_0000, 32'hFFFD_0000);
        for (int k = 0; k < 60 && obs_q.size() < exp_q.size(); k++) @(negedge clk);
        repeat (4) @(negedge clk);
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL bias_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].r !== exp_q[i].r || obs_q[i].n !== exp_q[i].n || !obs_q[i].vr || !obs_q[i].vn) begin
                errors++; $display("FAIL bias_value[%0d] got=%h/%h exp=%h/%h", i, obs_q[i].r, obs_q[i].n, exp_q[i].r, exp_q[i].n); end
            checks++;
            if (obs_q[i].fr !== exp_q[i].fd || obs_q[i].fn !== exp_q[i].fd) begin
                errors++; $display("FAIL bias_frame[%0d] got=%b/%b exp=%b", i, obs_q[i].fr, obs_q[i].fn, exp_q[i].fd); end
            checks++;
            if (obs_q[i].cyc - exp_q[i].cyc != 3) begin
                errors++; $display("FAIL bias_latency[%0d] got=%0d exp=3", i, obs_q[i].cyc - exp_q[i].cyc); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_saturate();
        for (int c = 0; c < 3; c++) cfg_write(8'(c), 32'h0002_0000, 1'b1);
        cfg_write(8'd3, 32'h0, 1'b1);
        send_pixel(32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 0, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        send_pixel(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 0, 1'b0, 32'h0000_0000, 32'h8000_0000);
        for (int k = 0; k < 60 && obs_q.size() < exp_q.size(); k++) @(negedge clk);
        repeat (4) @(negedge clk);
        // Floor rounding of a tiny negative result: -2^-17 must become -1 LSB.
        cfg_write(8'd0, 32'h0000_8000, 1'b1);
        cfg_write(8'd1, 32'h0, 1'b1);
        cfg_write(8'd2, 32'h0, 1'b1);
        send_pixel(32'hFFFF_FFFF, 32'h0, 32'h0, 1, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF);
        for (int k = 0; k < 60 && obs_q.size() < exp_q.size(); k++) @(negedge clk);
        repeat (4) @(negedge clk);
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL sat_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].r !== exp_q[i].r || obs_q[i].n !== exp_q[i].n || !obs_q[i].vr || !obs_q[i].vn) begin
                errors++; $display("FAIL sat_value[%0d] got=%h/%h exp=%h/%h", i, obs_q[i].r, obs_q[i].n, exp_q[i].r, exp_q[i].n); end
            checks++;
            if (obs_q[i].fr !== exp_q[i].fd || obs_q[i].fn !== exp_q[i].fd) begin
                errors++; $display("FAIL sat_frame[%0d] got=%b/%b exp=%b", i, obs_q[i].fr, obs_q[i].fn, exp_q[i].fd); end
            checks++;
            if (obs_q[i].cyc - exp_q[i].cyc != 3) begin
                errors++; $display("FAIL sat_latency[%0d] got=%0d exp=3", i, obs_q[i].cyc - exp_q[i].cyc); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_cfg_drop();
        int cy;
        for (int c = 0; c < 3; c++) cfg_write(8'(c), 32'h0001_0000, 1'b1);
        cfg_write(8'd3, 32'h0, 1'b1);
        drive_sample(32'h0001_0000, cy);
        cfg_write(8'd0, 32'h0005_0000, 1'b0);
        checks++;
        if (ce_r !== 1'b1 || ce_n !== 1'b1) begin
            errors++; $display("FAIL drop_cfg_err got=%b/%b exp=1", ce_r, ce_n); end
        drive_sample(32'h0001_0000, cy);
        drive_sample(32'h0001_0000, cy);
        push_exp(32'h0003_0000, 32'h0003_0000, cy);
        send_pixel(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 0, 1'b0, 32'h0006_0000, 32'h0006_0000);
        for (int k = 0; k < 60 && obs_q.size() < exp_q.size(); k++) @(negedge clk);
        repeat (4) @(negedge clk);
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL drop_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].r !== exp_q[i].r || obs_q[i].n !== exp_q[i].n || !obs_q[i].vr || !obs_q[i].vn) begin
                errors++; $display("FAIL drop_value[%0d] got=%h/%h exp=%h/%h", i, obs_q[i].r, obs_q[i].n, exp_q[i].r, exp_q[i].n); end
            checks++;
            if (obs_q[i].fr !== exp_q[i].fd || obs_q[i].fn !== exp_q[i].fd) begin
                errors++; $display("FAIL drop_frame[%0d] got=%b/%b exp=%b", i, obs_q[i].fr, obs_q[i].fn, exp_q[i].fd); end
            checks++;
            if (obs_q[i].cyc - exp_q[i].cyc != 3) begin
                errors++; $display("FAIL drop_latency[%0d] got=%0d exp=3", i, obs_q[i].cyc - exp_q[i].cyc); end
        end
        checks++;
        if (ce_r !== 1'b1) begin errors++; $display("FAIL drop_err_sticky got=%b exp=1", ce_r); end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset();
        Valid_In = 1'b0;
        Cfg_We   = 1'b0;
        rst      = 1'b0;
        @(negedge clk);
        checks++;
        if (dout_r !== 32'h0 || vo_r !== 1'b0 || fd_r !== 1'b0 || ce_r !== 1'b0) begin
            errors++; $display("FAIL reset_relu got=%h vo=%b fd=%b err=%b exp=0", dout_r, vo_r, fd_r, ce_r); end
        checks++;
        if (dout_n !== 32'h0 || vo_n !== 1'b0 || fd_n !== 1'b0 || ce_n !== 1'b0) begin
            errors++; $display("FAIL reset_lin got=%h vo=%b fd=%b err=%b exp=0", dout_n, vo_n, fd_n, ce_n); end
        do_reset();
    endtask

    task automatic test_reset_mid();
        int cy;
        for (int c = 0; c < 3; c++) cfg_write(8'(c), 32'h0002_0000, 1'b1);
        drive_sample(32'h0001_0000, cy);
        drive_sample(32'h0001_0000, cy);
        do_reset();
        repeat (6) @(negedge clk);
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL midrst_stale got=%0d outputs exp=0", obs_q.size()); end
        send_pixel(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 0, 1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 60 && obs_q.size() < exp_q.size(); k++) @(negedge clk);
        repeat (4) @(negedge clk);
        for (int c = 0; c < 3; c++) cfg_write(8'(c), 32'h0001_0000, 1'b1);
        send_pixel(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 0, 1'b0, 32'h0006_0000, 32'h0006_0000);
        for (int k = 0; k < 60 && obs_q.size() < exp_q.size(); k++) @(negedge clk);
        repeat (4) @(negedge clk);
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL midrst_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].r !== exp_q[i].r || obs_q[i].n !== exp_q[i].n || !obs_q[i].vr || !obs_q[i].vn) begin
                errors++; $display("FAIL midrst_value[%0d] got=%h/%h exp=%h/%h", i, obs_q[i].r, obs_q[i].n, exp_q[i].r, exp_q[i].n); end
            checks++;
            if (obs_q[i].cyc - exp_q[i].cyc != 3) begin
                errors++; $display("FAIL midrst_latency[%0d] got=%0d exp=3", i, obs_q[i].cyc - exp_q[i].cyc); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        load_random_cfg();
        for (int p = 0; p < 4; p++) send_pixel(rand_fix(), rand_fix(), rand_fix(), 0, 1'b1, 32'h0, 32'h0);
        for (int k = 0; k < 60 && obs_q.size() < exp_q.size(); k++) @(negedge clk);
        repeat (4) @(negedge clk);
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].r !== exp_q[i].r || obs_q[i].n !== exp_q[i].n || !obs_q[i].vr || !obs_q[i].vn) begin
                errors++; $display("FAIL b2b_value[%0d] got=%h/%h exp=%h/%h", i, obs_q[i].r, obs_q[i].n, exp_q[i].r, exp_q[i].n); end
            checks++;
            if (obs_q[i].fr !== exp_q[i].fd || obs_q[i].fn !== exp_q[i].fd) begin
                errors++; $display("FAIL b2b_frame[%0d] got=%b/%b exp=%b", i, obs_q[i].fr, obs_q[i].fn, exp_q[i].fd); end
            if (i > 0) begin
                checks++;
                if (obs_q[i].cyc - obs_q[i-1].cyc != 3) begin
                    errors++; $display("FAIL b2b_spacing[%0d] got=%0d exp=3", i, obs_q[i].cyc - obs_q[i-1].cyc); end
            end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_frame();
        int pulses;
        do_reset();
        load_random_cfg();
        for (int p = 0; p < 9; p++) send_pixel(rand_fix(), rand_fix(), rand_fix(), 3, 1'b1, 32'h0, 32'h0);
        for (int k = 0; k < 60 && obs_q.size() < exp_q.size(); k++) @(negedge clk);
        repeat (4) @(negedge clk);
        checks++;
        if (obs_q.size() != 9) begin errors++; $display("FAIL frame_count got=%0d exp=9", obs_q.size()); end
        pulses = 0;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            if (obs_q[i].fr) pulses++;
            checks++;
            if (obs_q[i].r !== exp_q[i].r || obs_q[i].n !== exp_q[i].n || !obs_q[i].vr || !obs_q[i].vn) begin
                errors++; $display("FAIL frame_value[%0d] got=%h/%h exp=%h/%h", i, obs_q[i].r, obs_q[i].n, exp_q[i].r, exp_q[i].n); end
            checks++;
            if (obs_q[i].fr !== exp_q[i].fd || obs_q[i].fn !== exp_q[i].fd) begin
                errors++; $display("FAIL frame_flag[%0d] got=%b/%b exp=%b", i, obs_q[i].fr, obs_q[i].fn, exp_q[i].fd); end
            checks++;
            if (obs_q[i].cyc - exp_q[i].cyc != 3) begin
                errors++; $display("FAIL frame_latency[%0d] got=%0d exp=3", i, obs_q[i].cyc - exp_q[i].cyc); end
        end
        checks++;
        if (pulses != 2) begin errors++; $display("FAIL frame_pulses got=%0d exp=2", pulses); end
        obs_q.delete(); exp_q.delete();
    endtask

    initial begin
        rst      = 1'b0;
        Cfg_We   = 1'b0;
        Cfg_Addr = '0;
        Cfg_Data = '0;
        Data_In  = '0;
        Valid_In = 1'b0;
        repeat (3) @(negedge clk);
        do_reset();
        test_basic();
        test_bias_relu();
        test_saturate();
        test_cfg_drop();
        test_reset();
        test_reset_mid();
        test_back_to_back();
        test_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pointwise_mac_1x1.md
POINTWISE_MAC_1X1 -- requirements
Module: pointwise_mac_1x1

Interface
REQ-001 Parameter DATA_WIDHT, default 32: signed two's-complement width of pixel, weight, bias and output samples.
REQ-002 Parameter FRAC_BITS, default 16: fractional bits of all fixed-point samples (Q(DATA_WIDHT-FRAC_BITS).FRAC_BITS).
REQ-003 Parameter CHANNELS, default 3, range 1..255: input channels summed into one output pixel.
REQ-004 Parameter OUT_PIXELS, default 22500 (150x150): output pixels per frame.
REQ-005 Parameter RELU_EN, default 1: 1 clamps negative results to 0.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst  input  1  synchronous, active-low reset.
REQ-008 Cfg_We  input  1  config write strobe.
REQ-009 Cfg_Addr  input  8  0..CHANNELS-1 selects a weight; CHANNELS selects bias; other values ignored.
REQ-010 Cfg_Data  input  DATA_WIDHT  weight/bias value.
REQ-011 Data_In  input  DATA_WIDHT  stride-decimated pixel sample, channel-interleaved (ch0, ch1, ..., chN-1 per pixel).
REQ-012 Valid_In  input  1  Data_In qualifier; no backpressure, every asserted cycle is consumed.
REQ-013 Data_Out  output  DATA_WIDHT  pointwise-convolved pixel.
REQ-014 Valid_Out  output  1  one-cycle qualifier for Data_Out.
REQ-015 Frame_Done  output  1  one-cycle pulse coincident with the Valid_Out of the last pixel of a frame.
REQ-016 Cfg_Err  output  1  sticky flag: a config write was dropped.

Function
REQ-017 Weight file: CHANNELS registers plus one bias register; written when Cfg_We=1, Cfg_Addr valid and channel counter = 0 with no sample in the pipeline.
REQ-018 A Cfg_We while the channel counter != 0 or the pipeline is non-empty shall be dropped and shall set Cfg_Err; Cfg_Err clears only on reset.
REQ-019 Channel counter ch increments on each Valid_In, wraps CHANNELS-1 -> 0; Valid_In=0 cycles hold it (gaps allowed anywhere).
REQ-020 Stage 1: on Valid_In, register full-precision signed product Data_In x W[ch] (2*DATA_WIDHT bits), with first/last-channel tags.
REQ-021 Stage 2: accumulator (2*DATA_WIDHT+8 bits) loads the product when tagged first, else adds it; no overflow possible for CHANNELS<=255.
REQ-022 Stage 3: when the last-channel product has been accumulated, compute (acc + sign-extended bias<<FRAC_BITS) >>> FRAC_BITS (arithmetic shift, floor rounding).
REQ-023 Stage 3 result shall saturate to [-2^(DATA_WIDHT-1), 2^(DATA_WIDHT-1)-1], then clamp to 0 if negative and RELU_EN=1, and register into Data_Out with Valid_Out=1.
REQ-024 Latency: Valid_Out asserts exactly 3 clock edges after the edge that samples the last-channel Valid_In, independent of input gaps.
REQ-025 Back-to-back pixels (Valid_In every cycle) yield one output every CHANNELS cycles; CHANNELS=1 yields one output per cycle.
REQ-026 Data_Out holds its last value while Valid_Out=0.
REQ-027 Pixel counter increments on each Valid_Out; at OUT_PIXELS-1 Frame_Done pulses with that Valid_Out and the counter wraps to 0.
REQ-028 Weight/bias changes never affect a pixel already in progress (guaranteed by REQ-017/018).

Reset
REQ-029 While rst=0 at a clock edge: Data_Out=0, Valid_Out=0, Frame_Done=0, Cfg_Err=0, channel and pixel counters=0, pipeline valid tags=0, weights=0, bias=0.
REQ-030 Reset mid-pixel or mid-pipeline discards partial sums; the first Valid_In after rst returns to 1 is channel 0 and no stale output appears.

Verification
REQ-031 FRAC_BITS=16, CHANNELS=3, W=0x00010000 each, bias 0, Data_In 0x00020000 x3 back-to-back -> Data_Out=0x00060000, Valid_Out 3 cycles after third sample.
REQ-032 Same, bias=0x00008000, W0=0xFFFF0000 (-1.0), data 0x00010000 x3 -> 0x00018000; with RELU_EN=1 and bias 0xFFFC0000 -> 0x00000000.
REQ-033 W=0x00020000 each, data 0x7FFF0000 x3 -> 0x7FFFFFFF; RELU_EN=0, data 0x80000000 x3 -> 0x80000000.
REQ-034 Cfg_We after first channel of a pixel -> weight unchanged, Cfg_Err=1, current and next outputs use old weight.
REQ-035 OUT_PIXELS=4, 9 pixels with random Valid_In gaps -> Frame_Done on outputs 4 and 8 only, latency per REQ-024 every pixel.
REQ-036 rst=0 for one cycle after 2 of 3 channels -> no Valid_Out; following 3 samples give a correct result using reset (zero) weights unless reloaded.
